// File: rtl/tm1637_serial_tx.sv
// tm1637_serial_tx: TM1637 two-wire frame transmitter paced by divider ticks, open-drain DIO.
module tm1637_serial_tx #(
  parameter bit CHECK_ACK = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       div_clk,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tm_clk,
  output logic       dio_oe,
  input  logic       dio_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, GAP, STOP} state_t;
  state_t state, state_nx;
  logic [1:0] ph, ph_nx, dio_s;
  logic [2:0] idx, idx_nx;
  logic [7:0] sh, sh_nx;
  logic last, last_nx, div_q, tick;
  logic tm_clk_nx, dio_oe_nx, busy_nx, done_nx, ready_nx, ack_err_nx;
  assign tick = div_clk & ~div_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ph         <= '0;
      idx        <= '0;
      sh         <= '0;
      last       <= 1'b0;
      div_q      <= 1'b0;
      dio_s      <= '0;
      tm_clk     <= 1'b1;
      dio_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_ready <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      ph         <= ph_nx;
      idx        <= idx_nx;
      sh         <= sh_nx;
      last       <= last_nx;
      div_q      <= div_clk;
      dio_s      <= {dio_s[0], dio_in};
      tm_clk     <= tm_clk_nx;
      dio_oe     <= dio_oe_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      byte_ready <= ready_nx;
      ack_err    <= ack_err_nx;
    end
  end
  always_comb begin
    state_nx   = state;
    ph_nx      = ph;
    idx_nx     = idx;
    sh_nx      = sh;
    last_nx    = last;
    tm_clk_nx  = tm_clk;
    dio_oe_nx  = dio_oe;
    busy_nx    = busy;
    done_nx    = 1'b0;
    ready_nx   = 1'b0;
    ack_err_nx = ack_err;
    if (tick) begin
      case (state)
        IDLE: if (byte_valid) begin
          sh_nx      = byte_data;
          last_nx    = byte_last;
          ready_nx   = 1'b1;
          ack_err_nx = 1'b0;
          busy_nx    = 1'b1;
          dio_oe_nx  = 1'b1;
          state_nx   = START;
        end
        START: begin
          tm_clk_nx = 1'b0;
          ph_nx     = '0;
          idx_nx    = '0;
          state_nx  = BIT;
        end
        BIT: begin
          ph_nx     = ph + 2'd1;
          dio_oe_nx = ph == 2'd0 ? ~sh[idx] : dio_oe;
          tm_clk_nx = ph == 2'd1 ? 1'b1 : ph == 2'd3 ? 1'b0 : tm_clk;
          idx_nx    = ph == 2'd3 ? idx + 3'd1 : idx;
          state_nx  = ph == 2'd3 && idx == 3'd7 ? ACK : BIT;
        end
        ACK: begin
          ph_nx      = ph + 2'd1;
          dio_oe_nx  = ph == 2'd0 ? 1'b0 : dio_oe;
          tm_clk_nx  = ph == 2'd1 ? 1'b1 : ph == 2'd3 ? 1'b0 : tm_clk;
          ack_err_nx = ack_err | (ph == 2'd2 && CHECK_ACK && dio_s[1]);
          state_nx   = ph != 2'd3 ? ACK : last ? STOP : GAP;
        end
        GAP: begin
          tm_clk_nx = 1'b0;
          dio_oe_nx = 1'b0;
          // the accepting tick doubles as Q0 of bit 0
          if (byte_valid) begin
            sh_nx     = byte_data;
            last_nx   = byte_last;
            ready_nx  = 1'b1;
            dio_oe_nx = ~byte_data[0];
            idx_nx    = '0;
            ph_nx     = 2'd1;
            state_nx  = BIT;
          end
        end
        STOP: begin
          ph_nx     = ph + 2'd1;
          dio_oe_nx = ph == 2'd0 ? 1'b1 : ph == 2'd2 ? 1'b0 : dio_oe;
          tm_clk_nx = ph == 2'd1 ? 1'b1 : tm_clk;
          done_nx   = ph == 2'd3;
          busy_nx   = ph != 2'd3;
          state_nx  = ph == 2'd3 ? IDLE : STOP;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

// File: doc/tm1637_serial_tx.md
Name: tm1637_serial_tx

Overview:
- Two-wire TM1637 transmitter downstream of divider_clock. Consumes its div_clk square wave as a bit-rate time base.
- Serialises host bytes into frames on the display pins: START, data bytes LSB-first each followed by an ACK slot, then STOP.
- DIO is open-drain: the block only drives low (dio_oe=1) or releases the line; the external pull-up supplies high.
- Sits between the display command sequencer (byte source) and the FPGA pins.

Parameters:
CHECK_ACK, 1, 1 = record a missing ACK in ack_err; 0 = ignore the ACK slot.

Ports:
clock  in  1  system clock; div_clk is synchronous to it.
reset_n  in  1  asynchronous active-low reset.
div_clk  in  1  divider output; each rising edge produces one internal tick.
byte_data  in  8  byte to send.
byte_last  in  1  qualifies byte_data: this byte is the final byte of the frame.
byte_valid  in  1  byte_data/byte_last valid; held until byte_ready.
byte_ready  out  1  one-clock accept pulse.
tm_clk  out  1  TM1637 CLK pin.
dio_oe  out  1  1 = drive DIO low; 0 = release DIO.
dio_in  in  1  DIO pin readback, asynchronous.
busy  out  1  frame in progress.
done  out  1  one-clock pulse at the end of STOP.
ack_err  out  1  sticky; a missing ACK occurred in the current or last frame.

Behaviour:
- Reset, asynchronous, all outputs: tm_clk=1, dio_oe=0, byte_ready=0, busy=0, done=0, ack_err=0. State=IDLE, all counters cleared. Reset mid-frame aborts immediately with no STOP generated.
- Tick: div_clk registered once; tick = div_clk & ~div_clk_q.
  - All state changes below happen only on clocks where tick=1.
  - The default divider gives 1 tick per 12 clocks.
- dio_in passes through a 2-flop synchroniser before use.
- IDLE: tm_clk=1, dio_oe=0. On a tick with byte_valid=1:
  - capture byte and last flag; byte_ready=1 for that clock;
  - clear ack_err; busy=1; dio_oe=1 (START: DIO falls while CLK high); go to START.
- START, 1 tick: tm_clk=0; go to BIT with bit index 0, phase Q0.
- BIT, 4 phases per bit, LSB first:
  - Q0: dio_oe = ~bit[i], tm_clk stays 0.
  - Q1: tm_clk=1.
  - Q2: hold.
  - Q3: tm_clk=0. If i=7 go to ACK, else i+1 and back to Q0.
- ACK, 4 phases:
  - Q0: dio_oe=0.
  - Q1: tm_clk=1.
  - Q2: sample the synchronised dio_in; if CHECK_ACK=1 and the sample is 1, set ack_err=1.
  - Q3: tm_clk=0.
  - Next state: STOP if the last flag is set, else GAP.
  - The transfer always continues, whatever the ACK result.
- GAP: tm_clk=0, dio_oe=0.
  - Wait any number of ticks for byte_valid.
  - On a tick with byte_valid=1: capture, byte_ready pulse, and this same tick acts as BIT Q0 of bit 0.
- STOP, 4 phases:
  - S0: dio_oe=1, tm_clk=0.
  - S1: tm_clk=1.
  - S2: dio_oe=0 (DIO rises while CLK high).
  - S3: done=1 for one clock, busy=0, go to IDLE.
- Timing: a 1-byte frame takes 42 ticks from accept tick to done tick. Each additional byte adds 36 ticks plus its GAP wait.
- tm_clk and dio_oe are registered outputs. DIO changes only while tm_clk=0, except at START and STOP.
- byte_valid rising between ticks is not accepted until the next tick.
- byte_valid falling before byte_ready is a protocol violation with undefined result; no check is required.
- byte_valid in IDLE with no tick: no action.
- done and a new accept can never coincide, because IDLE is entered only at S3.

Test Plan:
1. Reset mid-BIT with tm_clk=0 and dio_oe=1 -> same clock: tm_clk=1, dio_oe=0, busy=0. After release with byte_valid=0: stays idle indefinitely.
2. Single byte 0x40, byte_last=1, dio_in forced 0 in the ACK slot, default divider -> byte_ready 1 clock, busy high.
   - START, then DIO samples at CLK rises = 0,0,0,0,0,0,1,0.
   - 42 ticks (~504 clocks) to done; ack_err=0.
3. Same as 2 but dio_in=1 during ACK -> ack_err=1 after ACK Q2. Frame still completes with STOP; ack_err cleared on the next accept.
4. CHECK_ACK=0 with dio_in=1 -> ack_err stays 0.
5. Two bytes 0xC0 then 0xFF (last), second byte_valid delayed 5 ticks after first ACK:
   - tm_clk held 0 and dio released for 5 ticks;
   - second byte_ready pulse;
   - 16 CLK rising edges with data, 2 ACK slots, 1 STOP.
6. Protocol checker on every tick: DIO never changes while tm_clk=1, except START (fall) and STOP (rise); tm_clk toggles only on tick clocks.
